alu_writeback: RTL and testbench
================================

# alu_writeback

Result write-back stage directly downstream of the ALU. It captures the ALU result pair (`dst`, and optionally `dst_h`) when the core signals the results phase. It then writes the words to their destination over the shared data bus with a request/acknowledge handshake, honouring `is_bus_busy`. It signals completion to the core's state sequencer with a `next_state` pulse.

## Interface
- `DATA_W`, 32, data word width.
- `ADDR_W`, 32, bus address width.

- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `clk_oe`  in  1  half-rate enable; state advances only on edges where `clk_oe`=1.
- `start`  in  1  results-valid strobe from sequencer; sampled only in IDLE on enabled edges.
- `wide`  in  1  write high word too (MUL/DIV/ADD/SUB carry results); sampled with `start`.
- `dst_addr`  in  ADDR_W  destination address of low word.
- `dst_in`  in  DATA_W  low result word (ALU `dst_out`).
- `dst_h_in`  in  DATA_W  high result word (ALU `dst_h_out`).
- `is_bus_busy`  in  1  another master owns the bus; no new request may be raised while high.
- `wr_ack`  in  1  bus target accepted current write.
- `wr_en`  out  1  write request, held until acknowledged.
- `wr_addr`  out  ADDR_W  write address.
- `wr_data`  out  DATA_W  write data.
- `busy`  out  1  block holds an uncompleted result.
- `next_state`  out  1  completion pulse to sequencer.

## Operation
- States: IDLE, REQ_LO, WAIT_LO, REQ_HI, WAIT_HI, DONE.
- Reset values:
  - state IDLE.
  - `wr_en`, `busy` and `next_state` all 0.
  - `wr_addr` and `wr_data` both 0.
  - Latched result registers 0.
  - Reset wins over every other input, including `clk_oe`=0.
- IDLE: on `start`=1, latch `dst_in`, `dst_h_in`, `dst_addr`, `wide`; set `busy`=1; go REQ_LO.
- REQ_LO, when `is_bus_busy`=0:
  - drive `wr_en`=1, `wr_addr`=latched addr, `wr_data`=latched dst;
  - go WAIT_LO.
- REQ_LO, when `is_bus_busy`=1: remain, `wr_en`=0.
- WAIT_LO:
  - hold `wr_en`, `wr_addr` and `wr_data` stable until `wr_ack`=1.
  - On ack: drop `wr_en`, then go REQ_HI if `wide`, else DONE.
- REQ_HI/WAIT_HI: same as the LO states, with `wr_addr`=latched addr+1 and `wr_data`=latched dst_h.
- Address arithmetic is modulo 2^ADDR_W: addr all-ones+1 wraps to 0.
- DONE:
  - `next_state`=1, `busy`=0, then go IDLE.
  - `wr_addr` and `wr_data` keep their last values.
- `start` outside IDLE is ignored and not queued. The sequencer must not reissue `start` before `next_state`.
- `wr_ack` outside WAIT_* is ignored.
- `is_bus_busy` rising while already in WAIT_* does not withdraw the request; the grant is considered held.

## Timing
- All transitions occur on posedge `clk` with `clk_oe`=1.
- Edges with `clk_oe`=0:
  - clear `next_state` to 0;
  - change nothing else (except reset).
- `next_state` is therefore high for exactly one clk cycle.
- Minimum latency, narrow result, bus free, ack on the first enabled edge after request: 4 enabled edges, `start` to `next_state`. The four edges are start→REQ_LO, →WAIT_LO, ack→DONE, DONE pulse.
- Minimum latency, wide result: 6 enabled edges.
- `wr_ack` arriving the same enabled edge `wr_en` is first driven is not yet seen; ack is sampled from the following enabled edge.
- Reset mid-transaction:
  - `wr_en` is 0 after the reset edge;
  - the partial write is abandoned and no `next_state` is issued.
- A simultaneous `start` and `rst` resolves to reset.

## Test plan
- Narrow write:
  - stimulus: `dst_addr`=0x100, `dst_in`=0xDEADBEEF, `wide`=0, bus free, ack after 1 enabled edge;
  - response: one write 0x100←0xDEADBEEF, and `next_state` pulses once, 4 enabled edges after `start`.
- Wide write:
  - stimulus: `dst_in`=0x1, `dst_h_in`=0x2, addr 0x200;
  - response: writes 0x200←0x1 then 0x201←0x2, in order, and a single `next_state`.
- Bus contention:
  - stimulus: hold `is_bus_busy`=1 for 5 enabled edges after `start`;
  - response: `wr_en` stays 0 throughout, then asserts on the first edge with busy low; completion is delayed by 5 edges.
- Slow target:
  - stimulus: delay `wr_ack` 7 enabled edges;
  - response: `wr_en`, `wr_addr` and `wr_data` remain constant; `start` pulses issued meanwhile are ignored.
- Wrap and reset:
  - Wide write at addr 0xFFFFFFFF: second write goes to 0x0.
  - Separately, `rst` asserted in WAIT_HI: `wr_en`=0 next edge, all outputs at reset values, no `next_state`.
- `clk_oe` gating:
  - stimulus: toggle `clk_oe` every cycle;
  - response: `next_state` is high exactly one clk cycle, and no state advances on `clk_oe`=0 edges.

Source files
------------

// File: rtl/alu_writeback.sv
// alu_writeback: result write-back stage behind the ALU.
// Captures the low/high result words when the sequencer strobes start. Writes them
// to the shared data bus with a request/acknowledge handshake, backing off while
// another master owns the bus. Then pulses next_state back to the sequencer.
// All state advances only on clock edges qualified by the half-rate enable clk_oe.
module alu_writeback #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_oe,
  input  logic              start,
  input  logic              wide,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [DATA_W-1:0] dst_in,
  input  logic [DATA_W-1:0] dst_h_in,
  input  logic              is_bus_busy,
  input  logic              wr_ack,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              next_state
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] REQ_LO  = 3'd1;
  localparam logic [2:0] WAIT_LO = 3'd2;
  localparam logic [2:0] REQ_HI  = 3'd3;
  localparam logic [2:0] WAIT_HI = 3'd4;
  localparam logic [2:0] DONE    = 3'd5;

  // Registered state, latched result and registered outputs
  logic [2:0]        state_r;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] dst_r;
  logic [DATA_W-1:0] dst_h_r;
  logic              wide_r;
  logic              wr_en_r;
  logic [ADDR_W-1:0] wr_addr_r;
  logic [DATA_W-1:0] wr_data_r;
  logic              busy_r;
  logic              next_state_r;

  // Next-state values computed combinationally
  logic [2:0]        state_s;
  logic              latch_s;
  logic              wr_en_s;
  logic [ADDR_W-1:0] wr_addr_s;
  logic [DATA_W-1:0] wr_data_s;
  logic              busy_s;
  logic              next_state_s;
  logic [ADDR_W-1:0] addr_hi_s;

  // High word goes to the next address; the sum wraps modulo 2^ADDR_W
  assign addr_hi_s = addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};

  assign wr_en      = wr_en_r;
  assign wr_addr    = wr_addr_r;
  assign wr_data    = wr_data_r;
  assign busy       = busy_r;
  assign next_state = next_state_r;

  // Sequencing: decide next state and outputs; without clk_oe everything holds except next_state, which falls
  always_comb begin
    state_s      = state_r;
    latch_s      = 1'b0;
    wr_en_s      = wr_en_r;
    wr_addr_s    = wr_addr_r;
    wr_data_s    = wr_data_r;
    busy_s       = busy_r;
    next_state_s = 1'b0;
    if (clk_oe) begin
      case (state_r)
        IDLE: begin
          if (start) begin
            latch_s = 1'b1;
            busy_s  = 1'b1;
            state_s = REQ_LO;
          end else begin
            state_s = IDLE;
          end
        end
        REQ_LO: begin
          if (!is_bus_busy) begin
            wr_en_s   = 1'b1;
            wr_addr_s = addr_r;
            wr_data_s = dst_r;
            state_s   = WAIT_LO;
          end else begin
            wr_en_s = 1'b0;
          end
        end
        WAIT_LO: begin
          // The grant is held once requested, so is_bus_busy is not consulted here
          if (wr_ack) begin
            wr_en_s = 1'b0;
            state_s = wide_r ? REQ_HI : DONE;
          end else begin
            wr_en_s = 1'b1;
          end
        end
        REQ_HI: begin
          if (!is_bus_busy) begin
            wr_en_s   = 1'b1;
            wr_addr_s = addr_hi_s;
            wr_data_s = dst_h_r;
            state_s   = WAIT_HI;
          end else begin
            wr_en_s = 1'b0;
          end
        end
        WAIT_HI: begin
          if (wr_ack) begin
            wr_en_s = 1'b0;
            state_s = DONE;
          end else begin
            wr_en_s = 1'b1;
          end
        end
        DONE: begin
          next_state_s = 1'b1;
          busy_s       = 1'b0;
          state_s      = IDLE;
        end
        default: begin
          state_s = IDLE;
          wr_en_s = 1'b0;
          busy_s  = 1'b0;
        end
      endcase
    end else begin
      next_state_s = 1'b0;
    end
  end

  // State, output and result registers; synchronous reset overrides clk_oe and start
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      addr_r       <= {ADDR_W{1'b0}};
      dst_r        <= {DATA_W{1'b0}};
      dst_h_r      <= {DATA_W{1'b0}};
      wide_r       <= 1'b0;
      wr_en_r      <= 1'b0;
      wr_addr_r    <= {ADDR_W{1'b0}};
      wr_data_r    <= {DATA_W{1'b0}};
      busy_r       <= 1'b0;
      next_state_r <= 1'b0;
    end else begin
      state_r      <= state_s;
      wr_en_r      <= wr_en_s;
      wr_addr_r    <= wr_addr_s;
      wr_data_r    <= wr_data_s;
      busy_r       <= busy_s;
      next_state_r <= next_state_s;
      if (latch_s) begin
        addr_r  <= dst_addr;
        dst_r   <= dst_in;
        dst_h_r <= dst_h_in;
        wide_r  <= wide;
      end
    end
  end

endmodule

// File: tb/tb_alu_writeback.sv
// Bench for alu_writeback: a transaction-level model (queue of pending bus writes)
// checked against the DUT outputs every clock, directed scenarios pinned with
// literal expectations, then randomized traffic.
module tb_alu_writeback;
  localparam int DW = 32;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst, clk_oe, start, wide, is_bus_busy, wr_ack;
  logic [AW-1:0] dst_addr;
  logic [DW-1:0] dst_in, dst_h_in;
  logic          wr_en, busy, next_state;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

  alu_writeback #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .clk_oe(clk_oe), .start(start), .wide(wide),
    .dst_addr(dst_addr), .dst_in(dst_in), .dst_h_in(dst_h_in),
    .is_bus_busy(is_bus_busy), .wr_ack(wr_ack), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .next_state(next_state)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: list of writes still owed for the current result
  logic [63:0] mq[$];
  bit          m_issued = 1'b0;
  bit          m_pulse_due = 1'b0;
  logic        m_wr_en = 1'b0, m_busy = 1'b0, m_ns = 1'b0;
  logic [31:0] m_addr = 32'h0, m_data = 32'h0;

  // Observation of the DUT
  logic [63:0] wlog[$];
  int          en_cnt = 0, ns_count = 0, last_ns_en = 0, ns_run = 0, ns_max_run = 0;
  logic        p_wr_en = 1'b0;
  logic [31:0] p_addr = 32'h0, p_data = 32'h0;

  // Model update on each edge, then compare
  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        mq.delete();
        m_issued = 1'b0; m_pulse_due = 1'b0;
        m_wr_en = 1'b0; m_busy = 1'b0; m_ns = 1'b0;
        m_addr = 32'h0; m_data = 32'h0;
      end else if (!clk_oe) begin
        m_ns = 1'b0;
      end else begin
        en_cnt++;
        if (p_wr_en && wr_ack) wlog.push_back({p_addr, p_data});
        m_ns = 1'b0;
        if (m_pulse_due) begin
          m_ns = 1'b1; m_busy = 1'b0; m_pulse_due = 1'b0;
        end else if (m_issued) begin
          if (wr_ack) begin
            m_issued = 1'b0; m_wr_en = 1'b0;
            void'(mq.pop_front());
            if (mq.size() == 0) m_pulse_due = 1'b1;
          end
        end else if (mq.size() > 0) begin
          if (!is_bus_busy) begin
            m_issued = 1'b1; m_wr_en = 1'b1;
            m_addr = mq[0][63:32]; m_data = mq[0][31:0];
          end
        end else if (start) begin
          mq.push_back({dst_addr, dst_in});
          if (wide) mq.push_back({dst_addr + 32'd1, dst_h_in});
          m_busy = 1'b1;
        end
      end
      #1;
      check("wr_en", wr_en, m_wr_en);
      check("wr_addr", wr_addr, m_addr);
      check("wr_data", wr_data, m_data);
      check("busy", busy, m_busy);
      check("next_state", next_state, m_ns);
      p_wr_en = wr_en; p_addr = wr_addr; p_data = wr_data;
      if (next_state) begin
        ns_count++; last_ns_en = en_cnt; ns_run++;
        if (ns_run > ns_max_run) ns_max_run = ns_run;
      end else begin
        ns_run = 0;
      end
    end
  end

  // Stimulus environment
  int oe_mode = 0;   // 0 always on, 1 toggle, 2 random
  bit rnd = 1'b0;
  int busy_hold = 0, ack_wait = 0, ack_cnt = 0, start_en = 0;
  bit pre_en = 1'b0, last_oe = 1'b0;

  task automatic tick();
    @(negedge clk);
    case (oe_mode)
      0:       clk_oe = 1'b1;
      1:       clk_oe = ~clk_oe;
      default: clk_oe = ($urandom_range(0, 3) != 0);
    endcase
    if (busy_hold > 0) is_bus_busy = 1'b1;
    else if (rnd) is_bus_busy = ($urandom_range(0, 2) == 0);
    else is_bus_busy = 1'b0;
    pre_en = wr_en;
    if (wr_en) begin
      wr_ack = (ack_cnt >= ack_wait);
    end else begin
      ack_cnt = 0;
      if (rnd) begin
        ack_wait = $urandom_range(0, 3);
        wr_ack = $urandom_range(0, 1) != 0;
      end else begin
        wr_ack = 1'b0;
      end
    end
    last_oe = clk_oe;
    @(posedge clk);
    if (clk_oe && pre_en && !wr_ack) ack_cnt++;
    if (clk_oe && busy_hold > 0) busy_hold--;
    #2;
  endtask

  task automatic issue(logic [31:0] a, logic [31:0] lo, logic [31:0] hi, logic w);
    dst_addr = a; dst_in = lo; dst_h_in = hi; wide = w; start = 1'b1;
    do tick(); while (!last_oe);
    start = 1'b0;
    start_en = en_cnt;
  endtask

  task automatic wait_ns(int base, int max);
    int k = 0;
    while (ns_count == base && k < max) begin
      tick();
      k++;
    end
    check("ns_timeout", ns_count - base, 1);
  endtask

  int b, l, k;

  initial begin
    rst = 1'b1; clk_oe = 1'b1; start = 1'b0; wide = 1'b0; is_bus_busy = 1'b0;
    wr_ack = 1'b0; dst_addr = '0; dst_in = '0; dst_h_in = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rst_wr_en", wr_en, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_next_state", next_state, 1'b0);
    check("rst_wr_addr", wr_addr, 32'h0);
    check("rst_wr_data", wr_data, 32'h0);

    // Narrow write
    b = ns_count; l = wlog.size();
    issue(32'h100, 32'hDEADBEEF, 32'h0, 1'b0);
    wait_ns(b, 60);
    repeat (3) tick();
    check("narrow_nwrites", wlog.size() - l, 1);
    check("narrow_write", wlog[l], {32'h100, 32'hDEADBEEF});
    check("narrow_latency", last_ns_en - start_en + 1, 4);
    check("narrow_pulses", ns_count - b, 1);

    // Wide write
    b = ns_count; l = wlog.size();
    issue(32'h200, 32'h1, 32'h2, 1'b1);
    wait_ns(b, 60);
    repeat (3) tick();
    check("wide_nwrites", wlog.size() - l, 2);
    check("wide_write_lo", wlog[l], {32'h200, 32'h1});
    check("wide_write_hi", wlog[l+1], {32'h201, 32'h2});
    check("wide_latency", last_ns_en - start_en + 1, 6);
    check("wide_pulses", ns_count - b, 1);

    // Bus contention for 5 enabled edges
    b = ns_count;
    issue(32'h300, 32'h12345678, 32'h0, 1'b0);
    busy_hold = 5;
    wait_ns(b, 60);
    repeat (3) tick();
    check("contention_latency", last_ns_en - start_en + 1, 9);

    // Slow target with ignored start pulses
    ack_wait = 7;
    b = ns_count; l = wlog.size();
    issue(32'h380, 32'hCAFEF00D, 32'h0, 1'b0);
    dst_addr = 32'h999; dst_in = 32'h999;
    for (int i = 0; i < 5; i++) begin
      start = (i % 2 == 0);
      tick();
    end
    start = 1'b0;
    wait_ns(b, 60);
    repeat (3) tick();
    ack_wait = 0;
    check("slow_nwrites", wlog.size() - l, 1);
    check("slow_write", wlog[l], {32'h380, 32'hCAFEF00D});
    check("slow_latency", last_ns_en - start_en + 1, 11);
    check("slow_pulses", ns_count - b, 1);

    // Address wrap
    b = ns_count; l = wlog.size();
    issue(32'hFFFFFFFF, 32'hA, 32'hB, 1'b1);
    wait_ns(b, 60);
    repeat (3) tick();
    check("wrap_write_lo", wlog[l], {32'hFFFFFFFF, 32'hA});
    check("wrap_write_hi", wlog[l+1], {32'h0, 32'hB});

    // Reset while waiting on the high word
    ack_wait = 3;
    b = ns_count; l = wlog.size();
    issue(32'h400, 32'h11, 32'h22, 1'b1);
    k = 0;
    while (!(wlog.size() == l + 1 && wr_en) && k < 60) begin
      tick();
      k++;
    end
    check("wait_hi_reached", wr_en, 1'b1);
    rst = 1'b1;
    tick();
    check("midrst_wr_en", wr_en, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_next_state", next_state, 1'b0);
    check("midrst_wr_addr", wr_addr, 32'h0);
    check("midrst_wr_data", wr_data, 32'h0);
    rst = 1'b0;
    ack_wait = 0;
    repeat (12) tick();
    check("midrst_no_pulse", ns_count - b, 0);
    check("midrst_nwrites", wlog.size() - l, 1);

    // clk_oe toggling every cycle
    oe_mode = 1;
    ns_max_run = 0;
    b = ns_count;
    issue(32'h500, 32'h55, 32'h0, 1'b0);
    wait_ns(b, 100);
    repeat (4) tick();
    check("oe_latency", last_ns_en - start_en + 1, 4);
    check("oe_pulse_width", ns_max_run, 1);
    check("oe_pulses", ns_count - b, 1);

    // Randomized traffic
    oe_mode = 2;
    rnd = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      start = ($urandom_range(0, 3) == 0);
      wide = $urandom_range(0, 1) != 0;
      dst_addr = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFF : $urandom;
      dst_in = $urandom;
      dst_h_in = $urandom;
      rst = ($urandom_range(0, 199) == 0);
      tick();
      rst = 1'b0;
    end
    start = 1'b0;
    rnd = 1'b0;
    oe_mode = 0;
    repeat (40) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
